// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 fetch-side types, sizes and default vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_TRAP_VEC = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_e;

    // JALR clears bit 0 of rs1+imm; branches are PC-relative.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic            jalr,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] off,
        input logic [XLEN-1:0] jalr_tgt
    );
        if (jalr) begin
            return {jalr_tgt[XLEN-1:1], 1'b0};
        end
        return pc + off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_ctrl
//  Description : Fetch PC sequencer with imem valid/ready handshake, EX-stage
//                redirect handling, IF/ID flush and misaligned-target trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_branch_off,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_jalr_tgt,
    input  logic             stall_in,
    input  logic             imem_req_ready,
    output logic             imem_req_valid,
    output logic [31:0]      imem_req_addr,
    output logic             flush_if,
    output logic             flush_id,
    output logic             misalign_trap,
    output logic [31:0]      trap_tval,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pending_q, pending_d;
    logic         flush_q, flush_d;
    logic         trap_q, trap_d;
    logic [31:0]  tval_q, tval_d;

    logic [31:0]  tgt;
    logic [31:0]  seq_pc;
    logic         redirect;
    logic         misaligned;
    logic         req_valid;
    logic         cnt_inc;

    assign tgt        = redirect_target(ex_jalr, ex_pc, ex_branch_off, ex_jalr_tgt);
    assign seq_pc     = ex_pc + 32'(INSN_BYTES);
    assign redirect   = ex_valid && (tgt != seq_pc);
    assign misaligned = (tgt[1:0] != 2'b00);

    // Stall only gates raising valid; an outstanding request keeps it high.
    assign req_valid  = (state_q == ST_RUN) && (pending_q || !stall_in);

    always_comb begin
        state_d   = ST_RUN;
        pc_d      = pc_q;
        pending_d = pending_q;
        flush_d   = 1'b0;
        trap_d    = 1'b0;
        tval_d    = tval_q;
        cnt_inc   = 1'b0;

        if (redirect) begin
            // Redirect overrides any same-cycle accept and any bubble state.
            flush_d   = 1'b1;
            pending_d = 1'b0;
            if (misaligned) begin
                state_d = ST_TRAP;
                pc_d    = TRAP_VEC;
                trap_d  = 1'b1;
                tval_d  = tgt;
            end else begin
                state_d = ST_REDIR;
                pc_d    = tgt;
                cnt_inc = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_valid && imem_req_ready) begin
                        pc_d      = pc_q + 32'(INSN_BYTES);
                        pending_d = 1'b0;
                    end else if (req_valid) begin
                        pending_d = 1'b1;
                    end
                end
                default: begin
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            flush_q   <= 1'b0;
            trap_q    <= 1'b0;
            tval_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
            trap_q    <= trap_d;
            tval_q    <= tval_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (cnt_inc),
        .o_count (redirect_cnt)
    );

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign flush_if       = flush_q;
    assign flush_id       = flush_q;
    assign misalign_trap  = trap_q;
    assign trap_tval      = tval_q;

endmodule
`default_nettype wire
